bbox_scan: RTL and testbench
============================

Name: bbox_scan

Overview:
- Per-frame bounding-box extractor for a binary threshold mask on the RGB image path.
- Tracks the min/max x and y of all foreground pixels within a frame, plus the foreground pixel count.
- Publishes a registered box, a valid flag and a done pulse at end of frame.
- Generalises the fixed 480x272 scanner: parametrised geometry, explicit frame-start sync, min-pixel qualification, simultaneous first-hit update of both bounds, and an abort on truncated frames.

Parameters:
- IMG_W, 480, active pixels per line.
- IMG_H, 272, active lines per frame.
- XW, 10, loc_x and box x-coordinate width; requires 2^XW >= IMG_W.
- YW, 10, loc_y and box y-coordinate width; requires 2^YW >= IMG_H.
- MIN_PIX, 16, minimum foreground count for box_valid = 1.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse before the first pixel of a frame.
- loc_x  in  XW  column of the current pixel.
- loc_y  in  YW  row of the current pixel.
- thres_de  in  1  pixel valid.
- thres_data  in  1  mask bit; 1 = foreground.
- box_lt_x  out  XW  left edge.
- box_lt_y  out  YW  top edge.
- box_rd_x  out  XW  right edge.
- box_rd_y  out  YW  bottom edge.
- box_pix_cnt  out  CW  foreground count, where CW = $clog2(IMG_W*IMG_H+1).
- box_valid  out  1  box qualified (count >= MIN_PIX).
- frame_done  out  1  one-cycle pulse when outputs update.
- frame_abort  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE.
  - All box outputs = 0; box_valid = 0; frame_done = 0; frame_abort = 0.
  - Accumulators: min_x = IMG_W-1, min_y = IMG_H-1, max_x = 0, max_y = 0, cnt = 0.
- IDLE:
  - Pixels are ignored.
  - frame_start -> load accumulator init values, go to SCAN.
- SCAN: on each thres_de && thres_data cycle:
  - Update min_x, max_x, min_y and max_y independently, all in the same cycle. No else-if coupling: a single pixel may set both min and max.
  - cnt saturates at its maximum.
- End of frame: thres_de && loc_x == IMG_W-1 && loc_y == IMG_H-1.
  - That last pixel is included in the accumulation.
  - Next cycle: outputs load from the accumulators, box_valid = (cnt_final >= MIN_PIX), frame_done = 1 for one cycle, state = IDLE.
  - Latency: last pixel at edge N -> outputs and frame_done visible after edge N+1.
- Empty or under-threshold frame:
  - Outputs are still loaded. With zero hits they hold the sentinels (lt = IMG_W-1 / IMG_H-1, rd = 0).
  - box_valid = 0.
  - Consumers must check box_valid.
- frame_start while in SCAN (truncated frame):
  - Discard the accumulators and do not touch the outputs.
  - frame_abort = 1 for one cycle.
  - Re-init the accumulators and stay in SCAN.
- frame_start in the same cycle as the end-of-frame pixel:
  - End-of-frame wins: complete and publish.
  - Then go to SCAN with fresh init instead of IDLE.
  - frame_abort stays 0.
- Out-of-range coordinates (loc_x >= IMG_W or loc_y >= IMG_H): ignore the pixel.
- Outputs hold their values between frame_done pulses.
- Reset mid-frame: immediate return to the reset state; no done or abort pulse.

Optional Feature:
- Macro: BBOX_SCAN_ROI_EN.
- Defined:
  - Adds parameters ROI_X0 = 0, ROI_Y0 = 0, ROI_X1 = IMG_W-1, ROI_Y1 = IMG_H-1.
  - Foreground pixels outside the inclusive ROI are not counted and do not move the bounds.
  - End-of-frame detection is unchanged: it still uses full-frame geometry.
- Undefined: the whole frame is the region; no ROI logic is synthesised.

Decomposition:
- Package bbox_pkg:
  - typedef enum state_t {IDLE, SCAN}.
  - Parameterised box struct helper (x/y min/max fields).
  - Function cnt_width() returning $clog2(w*h+1).
- Sub-module minmax_track:
  - One axis; parameter W.
  - Inputs: init, en, val. Outputs: min, max.
  - Instantiated twice (x, y).

Test Plan:
- Single hit at (100,50) in a 480x272 frame, MIN_PIX = 1 -> lt = (100,50), rd = (100,50), cnt = 1, valid = 1, frame_done exactly one cycle after pixel (479,271).
- Hits at (10,20), (300,5), (50,200) -> lt = (10,5), rd = (300,200), cnt = 3; with MIN_PIX = 16, valid = 0.
- All-zero mask -> lt = (479,271), rd = (0,0), cnt = 0, valid = 0, frame_done = 1.
- frame_start asserted again at (200,100) mid-frame -> frame_abort pulse; outputs keep the previous frame's values; the next complete frame reports only its own hits.
- frame_start coincident with end-of-frame pixel, then a hit at (5,5) in the next frame -> first frame published; second frame reports (5,5) with no abort.
- rst_n low at (240,136) of a full-foreground frame -> all outputs 0 immediately; no frame_done until a new frame_start plus a full frame.

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared types and helpers for the bounding-box scanner.
package bbox_pkg;

  typedef enum logic {IDLE, SCAN} state_t;

  // Generic box container; coordinates up to BOX_CW bits, narrower users zero-extend.
  localparam int BOX_CW = 16;

  typedef struct packed {
    logic [BOX_CW-1:0] min_x;
    logic [BOX_CW-1:0] max_x;
    logic [BOX_CW-1:0] min_y;
    logic [BOX_CW-1:0] max_y;
  } box_t;

  function automatic int cnt_width(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/minmax_track.sv
// Single-axis min/max accumulator; init reloads sentinels, or seeds from val when en is also set.
module minmax_track #(
  parameter int           W        = 10,
  parameter logic [W-1:0] INIT_MIN = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic [W-1:0] min,
  output logic [W-1:0] max
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min <= INIT_MIN;
      max <= '0;
    end else if (init) begin
      min <= en ? val : INIT_MIN;
      max <= en ? val : '0;
    end else if (en) begin
      // independent compares: a lone first hit moves both bounds
      if (val < min) min <= val;
      if (val > max) max <= val;
    end
  end

endmodule

// File: rtl/bbox_scan.sv
// Per-frame bounding box of a binary mask, published one cycle after the last pixel.
// Optional ROI filtering enabled by defining BBOX_SCAN_ROI_EN.
module bbox_scan
  import bbox_pkg::*;
#(
  parameter int IMG_W   = 480,
  parameter int IMG_H   = 272,
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int MIN_PIX = 16,
`ifdef BBOX_SCAN_ROI_EN
  parameter int ROI_X0  = 0,
  parameter int ROI_Y0  = 0,
  parameter int ROI_X1  = IMG_W - 1,
  parameter int ROI_Y1  = IMG_H - 1,
`endif
  localparam int CW     = cnt_width(IMG_W, IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic [XW-1:0] loc_x,
  input  logic [YW-1:0] loc_y,
  input  logic          thres_de,
  input  logic          thres_data,
  output logic [XW-1:0] box_lt_x,
  output logic [YW-1:0] box_lt_y,
  output logic [XW-1:0] box_rd_x,
  output logic [YW-1:0] box_rd_y,
  output logic [CW-1:0] box_pix_cnt,
  output logic          box_valid,
  output logic          frame_done,
  output logic          frame_abort
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_t        state, state_nxt;
  logic          fin;
  logic          scan, in_rng, in_roi, eof, abort, hit, init;
  logic [XW-1:0] min_x, max_x;
  logic [YW-1:0] min_y, max_y;
  logic [CW-1:0] cnt;

  assign scan   = (state == SCAN);
  assign in_rng = (loc_x <= X_LAST) && (loc_y <= Y_LAST);
`ifdef BBOX_SCAN_ROI_EN
  assign in_roi = in_rng &&
                  (loc_x >= XW'(ROI_X0)) && (loc_x <= XW'(ROI_X1)) &&
                  (loc_y >= YW'(ROI_Y0)) && (loc_y <= YW'(ROI_Y1));
`else
  assign in_roi = in_rng;
`endif
  assign eof   = scan && thres_de && (loc_x == X_LAST) && (loc_y == Y_LAST);
  assign abort = scan && frame_start && !eof;
  // a pixel sharing the cycle with an aborting frame_start belongs to the discarded frame
  assign hit   = scan && thres_de && thres_data && in_roi && !abort;
  // fin && scan: frame_start coincided with the previous end-of-frame, start fresh now
  assign init  = (!scan && frame_start) || abort || (fin && scan);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = SCAN;
      SCAN:    if (eof) state_nxt = frame_start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  minmax_track #(.W(XW), .INIT_MIN(X_LAST)) u_trk_x (
    .clk(clk), .rst_n(rst_n), .init(init), .en(hit), .val(loc_x), .min(min_x), .max(max_x)
  );

  minmax_track #(.W(YW), .INIT_MIN(Y_LAST)) u_trk_y (
    .clk(clk), .rst_n(rst_n), .init(init), .en(hit), .val(loc_y), .min(min_y), .max(max_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (init)              cnt <= hit ? CW'(1) : '0;
    else if (hit && cnt != '1)  cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin         <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      box_lt_x    <= '0;
      box_lt_y    <= '0;
      box_rd_x    <= '0;
      box_rd_y    <= '0;
      box_pix_cnt <= '0;
      box_valid   <= 1'b0;
    end else begin
      fin         <= eof;
      frame_done  <= fin;
      frame_abort <= abort;
      if (fin) begin
        box_lt_x    <= min_x;
        box_lt_y    <= min_y;
        box_rd_x    <= max_x;
        box_rd_y    <= max_y;
        box_pix_cnt <= cnt;
        box_valid   <= (cnt >= CW'(MIN_PIX));
      end
    end
  end

endmodule

// File: tb/tb_bbox_scan.sv
// Randomised frame bench for bbox_scan against a per-frame hit-list reference model.
module tb_bbox_scan;

  localparam int W    = 32;
  localparam int H    = 16;
  localparam int XW   = 6;
  localparam int YW   = 5;
  localparam int MINP = 4;
  localparam int CW   = $clog2(W * H + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [XW-1:0] loc_x = '0;
  logic [YW-1:0] loc_y = '0;
  logic          thres_de = 1'b0;
  logic          thres_data = 1'b0;
  logic [XW-1:0] box_lt_x, box_rd_x;
  logic [YW-1:0] box_lt_y, box_rd_y;
  logic [CW-1:0] box_pix_cnt;
  logic          box_valid, frame_done, frame_abort;

  bbox_scan #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW), .MIN_PIX(MINP)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .loc_x(loc_x), .loc_y(loc_y),
    .thres_de(thres_de), .thres_data(thres_data), .box_lt_x(box_lt_x), .box_lt_y(box_lt_y),
    .box_rd_x(box_rd_x), .box_rd_y(box_rd_y), .box_pix_cnt(box_pix_cnt),
    .box_valid(box_valid), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int vec = 0, errs = 0;

  // reference model: frame membership, hit list, pending and published box
  bit in_frame = 0, pub_pend = 0;
  int qx[$], qy[$];
  int p_lx, p_ly, p_rx, p_ry, p_cnt;
  bit p_val;
  int o_lx = 0, o_ly = 0, o_rx = 0, o_ry = 0, o_cnt = 0;
  bit o_val = 0;
  int dpx[$], dpy[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs();
    chk("lt_x", 32'(box_lt_x), o_lx);
    chk("lt_y", 32'(box_lt_y), o_ly);
    chk("rd_x", 32'(box_rd_x), o_rx);
    chk("rd_y", 32'(box_rd_y), o_ry);
    chk("cnt", 32'(box_pix_cnt), o_cnt);
    chk("valid", 32'(box_valid), 32'(o_val));
  endtask

  task automatic summarize();
    p_lx = W - 1; p_ly = H - 1; p_rx = 0; p_ry = 0; p_cnt = qx.size();
    foreach (qx[i]) begin
      if (qx[i] < p_lx) p_lx = qx[i];
      if (qx[i] > p_rx) p_rx = qx[i];
      if (qy[i] < p_ly) p_ly = qy[i];
      if (qy[i] > p_ry) p_ry = qy[i];
    end
    p_val = (p_cnt >= MINP);
  endtask

  task automatic step(input bit fs, input bit de, input bit data, input int x, input int y);
    bit eof, ab, hit, done_e;
    frame_start = fs; thres_de = de; thres_data = data;
    loc_x = XW'(x); loc_y = YW'(y);
    eof    = in_frame && de && x == W - 1 && y == H - 1;
    ab     = in_frame && fs && !eof;
    hit    = in_frame && de && data && x < W && y < H && !ab;
    done_e = pub_pend;
    if (pub_pend) begin
      o_lx = p_lx; o_ly = p_ly; o_rx = p_rx; o_ry = p_ry; o_cnt = p_cnt; o_val = p_val;
      pub_pend = 0;
    end
    if (hit) begin qx.push_back(x); qy.push_back(y); end
    if (eof) begin
      summarize();
      qx.delete(); qy.delete();
      pub_pend = 1;
      in_frame = fs;
    end else if (ab) begin
      qx.delete(); qy.delete();
    end else if (!in_frame && fs) begin
      qx.delete(); qy.delete();
      in_frame = 1;
    end
    @(posedge clk); #1;
    chk("done", 32'(frame_done), 32'(done_e));
    chk("abort", 32'(frame_abort), 32'(ab));
    chk_outs();
  endtask

  function automatic bit is_pt(input int x, input int y);
    foreach (dpx[i]) if (dpx[i] == x && dpy[i] == y) return 1;
    return 0;
  endfunction

  // lead: emit frame_start first; abort_at: pixel index re-asserting frame_start (-1 none)
  task automatic frame(input bit lead, input int dens, input int abort_at, input bit fs_end,
                       input bit noise);
    if (lead) step(1, 0, 0, 0, 0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int idx;
        bit d, fs;
        idx = y * W + x;
        if (noise && $urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 2))
            0: step(0, 0, 1'($urandom), x, y);
            1: step(0, 1, 1, W + $urandom_range(0, 31 - W + 32), y);
            default: step(0, 1, 1, x, H + $urandom_range(0, 31 - H));
          endcase
        end
        fs = (idx == abort_at) || (fs_end && idx == W * H - 1);
        d  = is_pt(x, y) || ($urandom_range(0, 99) < dens);
        step(fs, 1, d, x, y);
      end
  endtask

  initial begin
    #1;
    chk_outs();
    chk("done_rst", 32'(frame_done), 0);
    chk("abort_rst", 32'(frame_abort), 0);
    @(negedge clk); rst_n = 1;
    // pixels in IDLE, including the end-of-frame location, are ignored
    step(0, 1, 1, 10, 5);
    step(0, 1, 1, W - 1, H - 1);
    step(0, 0, 0, 0, 0);

    dpx = '{10}; dpy = '{5};
    frame(1, 0, -1, 0, 0);
    dpx = '{2, 20, 5}; dpy = '{4, 1, 12};
    frame(1, 0, -1, 0, 0);
    dpx = '{0, 31, 7, 7}; dpy = '{0, 15, 3, 3};
    frame(1, 0, -1, 0, 0);
    dpx = '{0, 31, 7, 8}; dpy = '{0, 15, 3, 3};
    frame(1, 0, -1, 0, 1);
    dpx.delete(); dpy.delete();
    frame(1, 0, -1, 0, 1);

    frame(1, 3, 5 * W + 20, 0, 0);
    frame(1, 2, -1, 1, 0);
    dpx = '{5}; dpy = '{5};
    frame(0, 0, -1, 0, 0);
    dpx.delete(); dpy.delete();

    for (int f = 0; f < 5; f++)
      frame(1, (f == 4) ? 100 : $urandom_range(0, 10), -1, 0, 1);

    // reset in the middle of a full-foreground frame
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i <= 8 * W + 16; i++) step(0, 1, 1, i % W, i / W);
    rst_n = 0;
    #1;
    in_frame = 0; pub_pend = 0; qx.delete(); qy.delete();
    o_lx = 0; o_ly = 0; o_rx = 0; o_ry = 0; o_cnt = 0; o_val = 0;
    chk_outs();
    chk("done_mrst", 32'(frame_done), 0);
    @(negedge clk); rst_n = 1;
    for (int i = 8 * W + 17; i < W * H; i++) step(0, 1, 1, i % W, i / W);
    step(0, 0, 0, 0, 0);
    frame(1, 100, -1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
